mmio_input_port: RTL

//  CPU-side input peripheral: the inbound counterpart of the LED output path. Takes the

---
 rtl/mmio_input_port_pkg.sv | 30 +++
 rtl/debounce_bit.sv | 51 +++++
 rtl/mmio_input_port.sv | 109 ++++++++++
 3 files changed

// File: rtl/mmio_input_port_pkg.sv
// ============================================================================
// mmio_input_port_pkg: register map and decode helpers for the MMIO input port
// Rev 1.0
// ============================================================================
`default_nettype none

package mmio_input_port_pkg;

   localparam logic [31:0] MMIO_BASE_ADDR = 32'h0000_1010;

   localparam logic [3:0] OFS_SW_STATE  = 4'h0;
   localparam logic [3:0] OFS_KEY_STATE = 4'h4;
   localparam logic [3:0] OFS_KEY_EDGE  = 4'h8;
   localparam logic [3:0] OFS_IRQ_EN    = 4'hC;

   typedef enum logic [1:0] {
      REG_SW_STATE  = OFS_SW_STATE[3:2],
      REG_KEY_STATE = OFS_KEY_STATE[3:2],
      REG_KEY_EDGE  = OFS_KEY_EDGE[3:2],
      REG_IRQ_EN    = OFS_IRQ_EN[3:2]
   } reg_sel_e;

   // The register window is 16 bytes, so only the upper 28 address bits select it.
   function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
      return addr[31:4] == base[31:4];
   endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_bit.sv
// ============================================================================
// debounce_bit: 2-flop synchronizer, stability counter and debounced-rise pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_bit #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic din_async,
   output logic dout,
   output logic rise
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);

   logic          r_meta;
   logic          r_sync;
   logic [CW-1:0] r_cnt;
   logic          w_flip;

   // The debounced bit flips on the edge where the count saturates while still differing.
   assign w_flip = (r_sync != dout) && (r_cnt == C_LAST);
   assign rise   = w_flip & r_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_cnt  <= '0;
         dout   <= 1'b0;
      end else begin
         r_meta <= din_async;
         r_sync <= r_meta;
         if (r_sync == dout) begin
            r_cnt <= '0;
         end else if (w_flip) begin
            dout  <= r_sync;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mmio_input_port.sv
// ============================================================================
// mmio_input_port: debounced switches/keys exposed as MMIO registers with press IRQ
// Rev 1.0
// ============================================================================
`default_nettype none

module mmio_input_port
   import mmio_input_port_pkg::*;
#(
   parameter int          N_SW       = 10,
   parameter int          N_KEY      = 2,
   parameter int          DEB_CYCLES = 4,
   parameter logic [31:0] BASE_ADDR  = MMIO_BASE_ADDR
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SW-1:0]  sw_raw,
   input  logic [N_KEY-1:0] key_raw_n,
   input  logic             rd_en,
   input  logic             wr_en,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             rd_valid,
   output logic             irq
);

   logic [N_SW-1:0]  w_sw_state;
   logic [N_SW-1:0]  w_sw_rise_unused;
   logic [N_KEY-1:0] w_key_state;
   logic [N_KEY-1:0] w_key_rise;
   logic [N_KEY-1:0] r_key_edge;
   logic [N_KEY-1:0] r_irq_en;

   generate
      for (genvar i = 0; i < N_SW; i++) begin : g_sw
         debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk       (clk),
            .reset     (reset),
            .din_async (sw_raw[i]),
            .dout      (w_sw_state[i]),
            .rise      (w_sw_rise_unused[i])
         );
      end
      // Inverting ahead of the synchronizer keeps the reset value (0) meaning "released".
      for (genvar k = 0; k < N_KEY; k++) begin : g_key
         debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk       (clk),
            .reset     (reset),
            .din_async (~key_raw_n[k]),
            .dout      (w_key_state[k]),
            .rise      (w_key_rise[k])
         );
      end
   endgenerate

   logic             w_hit;
   logic             w_aligned;
   reg_sel_e         w_sel;
   logic [31:0]      w_rd_word;
   logic [N_KEY-1:0] w_w1c;
   logic             w_ien_we;
   logic             w_unused;

   assign w_hit     = in_window(addr, BASE_ADDR);
   assign w_aligned = (addr[1:0] == 2'b00);
   assign w_sel     = reg_sel_e'(addr[3:2]);
   assign w_w1c     = (wr_en && w_hit && w_aligned && w_sel == REG_KEY_EDGE)
                      ? wdata[N_KEY-1:0] : '0;
   assign w_ien_we  = wr_en && w_hit && w_aligned && (w_sel == REG_IRQ_EN);
   assign w_unused  = ^{wdata[31:N_KEY], w_sw_rise_unused};

   always_comb begin
      w_rd_word = '0;
      if (w_aligned) begin
         case (w_sel)
            REG_SW_STATE:  w_rd_word[N_SW-1:0]  = w_sw_state;
            REG_KEY_STATE: w_rd_word[N_KEY-1:0] = w_key_state;
            REG_KEY_EDGE:  w_rd_word[N_KEY-1:0] = r_key_edge;
            REG_IRQ_EN:    w_rd_word[N_KEY-1:0] = r_irq_en;
            default:       w_rd_word = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_key_edge <= '0;
         r_irq_en   <= '0;
         rdata      <= '0;
         rd_valid   <= 1'b0;
      end else begin
         rd_valid <= rd_en && w_hit;
         if (rd_en && w_hit) begin
            rdata <= w_rd_word;
         end
         // A press arriving on the same edge as its W1C wins.
         r_key_edge <= (r_key_edge & ~w_w1c) | w_key_rise;
         if (w_ien_we) begin
            r_irq_en <= wdata[N_KEY-1:0];
         end
      end
   end

   assign irq = |(r_key_edge & r_irq_en);

endmodule

`default_nettype wire
